// File: rtl/timer_pkg.sv
// Purpose  : shared definitions for the memory-mapped down-counter timer.
// Latency  : n/a (types, constants and helpers only).
// Backpress: n/a.
//
// Contents:
//   - word offsets of the bus-visible registers
//   - CTRL bit positions plus a packed view of the CTRL register
//   - mode encodings
//   - FSM state encoding
package timer_pkg;

    // Word offsets within the timer's bus window. Offset 3 is reserved and reads 0.
    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    // CTRL bit positions. Everything above CTRL_IM_BIT reads as zero.
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_W        = 4;

    // Mode encodings. The unused codes 2 and 3 fall through to one-shot
    // behaviour, because only MODE_RELOAD is ever tested for.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Packed CTRL image. The field order matches the bit positions above,
    // so a 4-bit slice of the bus word casts straight onto it.
    typedef struct packed {
        logic       im;    // [3]   interrupt mask, 1 = irq allowed out
        logic [1:0] mode;  // [2:1] MODE_ONESHOT / MODE_RELOAD
        logic       en;    // [0]   timer enable
    } ctrl_t;

    // FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    // Zero-extended bus view of CTRL.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {{(32 - CTRL_W){1'b0}}, c};
    endfunction

    // Only code 1 reloads; every other mode value behaves as one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Purpose  : memory-mapped down-counter timer with one-shot and auto-reload modes, driving one HWInt bit.
// Latency  : rdata/irq are combinational from registers (zero read latency); writes take effect at the next clk edge.
// Backpress: none; the bus port accepts a write every cycle and never stalls.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; clears every register and aborts any count
//   addr   - word offset: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved (reads 0)
//   we     - write strobe, sampled on the rising edge of clk
//   wdata  - write data
//   rdata  - combinational read data for addr; narrower registers are zero-extended
//   irq    - CTRL.IM & irq_flag
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    // Architectural state.
    ctrl_t              ctrl_q;
    logic [CNT_W-1:0]   preset_q;
    logic [CNT_W-1:0]   count_q;
    logic               irq_flag_q;
    state_t             state_q;

    // Bus write decode. Writes to COUNT and to the reserved offset are dropped.
    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == CTRL_OFF);
    assign preset_wr = we && (addr == PRESET_OFF);

    // Terminal count: the edge that moves CNT -> INT and raises irq_flag.
    // COUNT values 0 and 1 are both terminal. That makes PRESET = 0 behave
    // as PRESET = 1, and it keeps the counter from ever wrapping below zero.
    // This term is also used to stop a coincident bus acknowledge from
    // swallowing a fresh interrupt.
    logic flag_set;

    assign flag_set = (state_q == CNT) && ctrl_q.en && (count_q <= CNT_W'(1));

    // FSM, counter and register file share one process. Bus writes are
    // placed after the FSM updates, so a CTRL write in the same cycle that the
    // FSM auto-clears EN overrides the FSM. The acknowledge is gated by
    // flag_set, so the set wins when both happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_q.en) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    // PRESET is sampled only here. A PRESET write during CNT
                    // therefore affects the next period, not the current one.
                    count_q <= preset_q;
                    state_q <= CNT;
                end

                CNT: begin
                    if (!ctrl_q.en) begin
                        // Abort: COUNT freezes. A later re-enable goes
                        // through LOAD again.
                        state_q <= IDLE;
                    end else if (count_q > CNT_W'(1)) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        count_q    <= '0;
                        irq_flag_q <= 1'b1;
                        state_q    <= INT;
                    end
                end

                INT: begin
                    if (is_reload(ctrl_q.mode)) begin
                        // Auto-reload: the flag was high for exactly this one
                        // cycle. Start the next period.
                        irq_flag_q <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        // One-shot: the level interrupt stays until software
                        // acknowledges it. The timer disarms itself here.
                        ctrl_q.en <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (ctrl_wr) begin
                ctrl_q <= ctrl_t'(wdata[CTRL_W-1:0]);
            end

            if (preset_wr) begin
                preset_q <= wdata[CNT_W-1:0];
            end

            // Any write to CTRL or PRESET acknowledges the interrupt, unless
            // the flag is being raised on this same edge.
            if ((ctrl_wr || preset_wr) && !flag_set) begin
                irq_flag_q <= 1'b0;
            end
        end
    end

    // Combinational read mux. Registers narrower than 32 bits are zero-extended.
    always_comb begin
        rdata = '0;
        case (addr)
            CTRL_OFF:   rdata = ctrl_word(ctrl_q);
            PRESET_OFF: rdata = 32'(preset_q);
            COUNT_OFF:  rdata = 32'(count_q);
            default:    rdata = '0;
        endcase
    end

    // The mask acts on the output only; it never changes irq_flag itself.
    assign irq = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Purpose  : self-checking bench for timer_counter: register vectors, directed timing corners, randomized scenarios.
// Latency  : checks irq/rdata 1 ns after each rising edge, with inputs driven at the same point.
// Backpress: n/a.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus write that lands on the next rising edge. Returns 1 ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model. It is purely arithmetic in n, the number of edges
    // since the enabling CTRL write. The period is L = max(P,1) + 2. In each
    // period, COUNT is 0 for the first two edges (IDLE/LOAD), then P, P-1, ...
    // with a floor at 0. The flag rises at n = L. In reload mode this pattern
    // repeats modulo L.
    function automatic int model_count(input int n, input int p, input int l, input bit reload);
        int m;
        int v;
        if (!reload && n >= l) return 0;
        m = reload ? (n % l) : n;
        if (m < 2) return 0;
        v = p - (m - 2);
        return (v > 0) ? v : 0;
    endfunction

    function automatic bit model_irq(input int n, input int l, input bit reload, input bit im);
        if (!im) return 1'b0;
        return reload ? ((n % l) == 0) : (n >= l);
    endfunction

    initial begin
        vec_t        vecs[12];
        logic [31:0] v;
        bit          found;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        tick();
        tick();
        chk("reset_irq", {31'b0, irq}, 32'd0);
        reset = 1'b0;

        // ---------------- table-driven register access ----------------
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1, 2'd2, 32'h55,       32'h0,        1'b0};
        vecs[5]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000000C, 32'h0000000C, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 32'h00000000, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 2'd0, 32'h0,        32'h0,        1'b0};
        for (int i = 0; i < 12; i++) begin
            we    = vecs[i].we;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            tick();
            we = 1'b0;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        // ---------------- one-shot, PRESET = 3 ----------------
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int n = 1; n <= 7; n++) begin
            tick();
            chk($sformatf("oneshot_irq_n%0d", n), {31'b0, irq}, {31'b0, (n >= 5)});
        end
        rd(2'd0, v);
        chk("oneshot_ctrl_en_cleared", v, 32'h8);
        wr(2'd0, 32'h8);
        chk("oneshot_ack_irq", {31'b0, irq}, 32'd0);

        // ---------------- auto-reload, PRESET = 2 ----------------
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int n = 1; n <= 13; n++) begin
            tick();
            chk($sformatf("reload_irq_n%0d", n), {31'b0, irq}, {31'b0, ((n % 4) == 0)});
            rd(2'd2, v);
            chk($sformatf("reload_count_n%0d", n), v,
                ((n % 4) == 2) ? 32'd2 : (((n % 4) == 3) ? 32'd1 : 32'd0));
        end

        // ---------------- masked interrupt ----------------
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int n = 1; n <= 6; n++) begin
            tick();
            chk($sformatf("mask_irq_n%0d", n), {31'b0, irq}, 32'd0);
        end
        rd(2'd0, v);
        chk("mask_en_cleared", v, 32'h0);
        wr(2'd0, 32'h8);
        chk("mask_after_ack_irq", {31'b0, irq}, 32'd0);
        tick();
        chk("mask_after_ack_irq2", {31'b0, irq}, 32'd0);

        // ---------------- abort and re-enable ----------------
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rd(2'd2, v);
            if (v == 32'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached_count", {31'b0, found}, 32'd1);
        if (found) begin
            // The clearing write lands on the edge that takes COUNT to 6.
            // After that, COUNT must hold.
            wr(2'd0, 32'h8);
            for (int k = 0; k < 5; k++) begin
                rd(2'd2, v);
                chk($sformatf("abort_freeze_k%0d", k), v, 32'd6);
                chk($sformatf("abort_irq_k%0d", k), {31'b0, irq}, 32'd0);
                tick();
            end
            wr(2'd0, 32'h9);
            for (int n = 1; n <= 12; n++) begin
                tick();
                if (n == 1) begin
                    rd(2'd2, v);
                    chk("reenable_count_n1", v, 32'd6);
                end
                if (n == 2) begin
                    rd(2'd2, v);
                    chk("reenable_reload", v, 32'd10);
                end
                chk($sformatf("reenable_irq_n%0d", n), {31'b0, irq}, {31'b0, (n == 12)});
            end
        end

        // ---------------- PRESET = 0 acts as 1 ----------------
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk($sformatf("preset0_irq_n%0d", n), {31'b0, irq}, {31'b0, (n >= 3)});
        end

        // ---------------- reset mid-count ----------------
        do_reset();
        wr(2'd1, 32'h20);
        wr(2'd0, 32'h9);
        for (int n = 1; n <= 5; n++) tick();
        rd(2'd2, v);
        chk("midreset_precount", v, 32'd29);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_irq", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk($sformatf("midreset_addr%0d", a), v, 32'd0);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            rd(2'd2, v);
            chk($sformatf("midreset_idle_count%0d", n), v, 32'd0);
        end

        // ---------------- CTRL write on the CNT->INT edge ----------------
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int n = 1; n <= 4; n++) tick();
        chk("coincide_pre_irq", {31'b0, irq}, 32'd0);
        wr(2'd0, 32'h9);
        chk("coincide_irq", {31'b0, irq}, 32'd1);
        tick();
        rd(2'd0, v);
        chk("coincide_ctrl", v, 32'h8);
        chk("coincide_irq_held", {31'b0, irq}, 32'd1);

        // ---------------- CTRL write in INT: bus value wins over auto-clear ----------------
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int n = 1; n <= 5; n++) tick();
        wr(2'd0, 32'h9);
        rd(2'd0, v);
        chk("intwr_ctrl", v, 32'h9);
        chk("intwr_irq_acked", {31'b0, irq}, 32'd0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("intwr_rerun_irq_n%0d", n), {31'b0, irq}, {31'b0, (n == 5)});
        end

        // ---------------- randomized scenarios against the model ----------------
        for (int s = 0; s < 12; s++) begin
            int         p;
            int         l;
            logic [1:0] mode;
            bit         im;
            bit         reload;
            p      = int'($urandom_range(0, 6));
            mode   = 2'($urandom_range(0, 3));
            im     = 1'($urandom_range(0, 1));
            reload = (mode == 2'd1);
            l      = ((p > 1) ? p : 1) + 2;
            do_reset();
            wr(2'd1, 32'(p));
            wr(2'd0, {28'b0, im, mode, 1'b1});
            for (int n = 1; n <= 3 * l + 2; n++) begin
                tick();
                chk($sformatf("rand%0d_irq_n%0d", s, n), {31'b0, irq},
                    {31'b0, model_irq(n, l, reload, im)});
                rd(2'd2, v);
                chk($sformatf("rand%0d_count_n%0d", s, n), v, 32'(model_count(n, p, l, reload)));
                rd(2'd0, v);
                chk($sformatf("rand%0d_ctrl_n%0d", s, n), v,
                    {28'b0, im, mode, (reload || (n < l + 1))});
            end
            rd(2'd1, v);
            chk($sformatf("rand%0d_preset", s), v, 32'(p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
